modulo_controle_rolhas: RTL and testbench
=========================================

Name: modulo_controle_rolhas

Overview:
- Controller for the cork-stock register in the bottle corking station.
- Sequences one cork dispense per bottle with the corking actuator, decrementing a 5-bit stock counter on each completed dispense.
- Drives a req/ack refill handshake with the cork feeder when stock reaches the minimum threshold, and raises a fault on actuator timeout.
- Sits between the bottle-position sensor logic, the corking actuator and the feeder; its count output feeds the display and status logic.

Parameters:
- MAX_ROLHAS, 31, stock saturation ceiling; must fit 5 bits.
- MIN_THRESHOLD, 5, min_signal asserted while count <= this value.
- REFILL_QTY, 15, corks added per refill_ack.
- TIMEOUT_CYCLES, 255, max cycles in ACTUATE waiting for cork_done before fault.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  line running; deasserting returns the FSM to IDLE and clears fault
- cork_req  input  1  level, bottle in position awaiting a cork
- cork_done  input  1  level or pulse, actuator finished inserting the cork
- refill_ack  input  1  single-cycle pulse, feeder delivered REFILL_QTY corks
- cork_actuate  output  1  command to the actuator, held high in ACTUATE
- refill_req  output  1  registered, high from request until refill_ack
- count  output  5  current cork stock
- min_signal  output  1  count <= MIN_THRESHOLD (combinational from registered count)
- empty  output  1  count == 0
- fault  output  1  actuator timeout latched

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst_n); all flops clear immediately on rst_n low.
- Reset values: count=0, state=IDLE, timer=0, cork_actuate=0, refill_req=0, fault=0. Derived outputs out of reset: min_signal=1, empty=1.
- FSM states:
  - IDLE -> ACTUATE when enable & cork_req & count != 0. If count == 0, stay in IDLE (the bottle waits; empty is visible to the line).
  - ACTUATE: cork_actuate=1; the timer increments each cycle.
    - On cork_done: count decrements at that edge, timer clears, go to RELEASE.
    - If the timer reaches TIMEOUT_CYCLES-1 without cork_done: go to FAULT, fault=1, no decrement.
  - RELEASE: cork_actuate=0; wait for cork_req low, then go to IDLE. This guarantees exactly one cork per bottle even if cork_req is held.
  - FAULT: cork_actuate=0, fault=1; exit to IDLE only when enable=0. fault clears on that transition.
- enable=0 in any state: next state IDLE and cork_actuate=0 on the next edge. count and refill_req are kept.
- Refill handshake, independent of the FSM:
  - refill_req sets on the edge where enable & min_signal & !refill_req.
  - refill_req clears on the edge where refill_ack is sampled high.
  - refill_ack while refill_req=0 is ignored, with no count change.
- Count arithmetic: computed in 6 bits.
  - next = count + (ack_valid ? REFILL_QTY : 0) - (dec ? 1 : 0)
  - The result saturates at MAX_ROLHAS.
  - dec is only possible when count >= 1, so there is no underflow.
  - Simultaneous dec and ack: both apply in the same cycle. Example: 5 -> 19.
- Latency: cork_actuate rises 1 cycle after cork_req is sampled. count updates 1 cycle after cork_done or refill_ack is sampled.
- A refill that lifts count above MIN_THRESHOLD drops min_signal in the same cycle count updates. A new refill_req cannot assert before the following cycle.

Decomposition:
- Shared package rolhas_pkg holds:
  - the state encoding (IDLE, ACTUATE, RELEASE, FAULT, 2 bits);
  - the default constants MAX_ROLHAS, MIN_THRESHOLD, REFILL_QTY;
  - COUNT_W=5.
- One sub-module, modulo_timeout_rolhas, implements the timeout counter: clear/enable inputs, expired output, parameter TIMEOUT_CYCLES.
- Threshold compare and empty detect stay inline.

Test Plan:
- Reset then enable=1, count=0 -> min_signal=1, empty=1; refill_req=1 next cycle. refill_ack pulse -> count=15, refill_req=0, min_signal=0.
- count=15, cork_req held high, cork_done pulse after 3 cycles -> cork_actuate high 3 cycles, count=14; no second dispense until cork_req goes low then high again.
- count=6, one dispense -> count=5, min_signal=1, refill_req=1 one cycle later.
- count=5 with refill_req=1; cork_done and refill_ack in the same cycle -> count=19, refill_req=0. Separately, count=25 with refill_ack -> count=31 (saturated).
- ACTUATE with no cork_done for 255 cycles -> fault=1, cork_actuate=0, count unchanged. enable=0 -> fault=0, state=IDLE.
- rst_n pulsed low mid-ACTUATE, asynchronously to clk -> cork_actuate=0, count=0, refill_req=0, fault=0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/rolhas_pkg.sv
// Shared definitions for the cork-stock controller.
//   - FSM state encoding (2 bits)
//   - default stock constants and counter width
package rolhas_pkg;

    localparam int COUNT_W       = 5;
    localparam int MAX_ROLHAS    = 31;
    localparam int MIN_THRESHOLD = 5;
    localparam int REFILL_QTY    = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTUATE = 2'd1,
        RELEASE = 2'd2,
        FAULT   = 2'd3
    } state_t;

endpackage

// File: rtl/modulo_timeout_rolhas.sv
// Actuator timeout counter.
// Counts up while enable is high, returns to zero on clear, and holds once
// the last allowed cycle is reached.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - synchronous return to zero (has priority over enable)
//   enable     - count one step per cycle
//   expired    - high while the count sits at TIMEOUT_CYCLES-1
module modulo_timeout_rolhas #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer;

    assign expired = (timer == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (clear) begin
            timer <= '0;
        end else if (enable && !expired) begin
            timer <= timer + 1'b1;
        end
    end

endmodule

// File: rtl/modulo_controle_rolhas.sv
// Cork-stock controller for the bottle corking station.
// Sequences one cork dispense per bottle, tracks the 5-bit stock, runs the
// refill req/ack handshake with the feeder and latches actuator timeouts.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for a bottle (cork_req) with stock available
//   ACTUATE | actuator commanded, waiting for cork_done or timeout
//   RELEASE | cork inserted, waiting for the bottle to leave (cork_req low)
//   FAULT   | actuator timed out; held until the line is disabled
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   enable       - line running; low forces IDLE and clears fault
//   cork_req     - bottle in position
//   cork_done    - actuator finished inserting the cork
//   refill_ack   - feeder delivered REFILL_QTY corks (single-cycle pulse)
//   cork_actuate - actuator command (registered)
//   refill_req   - refill request to the feeder (registered)
//   count        - current stock
//   min_signal   - count <= MIN_THRESHOLD
//   empty        - count == 0
//   fault        - actuator timeout latched (registered)
module modulo_controle_rolhas #(
    parameter int MAX_ROLHAS     = rolhas_pkg::MAX_ROLHAS,
    parameter int MIN_THRESHOLD  = rolhas_pkg::MIN_THRESHOLD,
    parameter int REFILL_QTY     = rolhas_pkg::REFILL_QTY,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           cork_req,
    input  logic                           cork_done,
    input  logic                           refill_ack,
    output logic                           cork_actuate,
    output logic                           refill_req,
    output logic [rolhas_pkg::COUNT_W-1:0] count,
    output logic                           min_signal,
    output logic                           empty,
    output logic                           fault
);

    import rolhas_pkg::state_t, rolhas_pkg::COUNT_W;
    import rolhas_pkg::IDLE, rolhas_pkg::ACTUATE, rolhas_pkg::RELEASE, rolhas_pkg::FAULT;

    // One extra bit so refill plus stock can be compared against the ceiling
    localparam int SUM_W = COUNT_W + 1;
    localparam logic [SUM_W-1:0]   MAX_S    = SUM_W'(MAX_ROLHAS);
    localparam logic [SUM_W-1:0]   REFILL_S = SUM_W'(REFILL_QTY);
    localparam logic [COUNT_W-1:0] MIN_C    = COUNT_W'(MIN_THRESHOLD);

    state_t             state;
    state_t             state_next;
    logic               timer_clear;
    logic               timer_en;
    logic               timer_expired;
    logic               dec;
    logic               ack_valid;
    logic [SUM_W-1:0]   count_sum;
    logic [COUNT_W-1:0] count_next;

    assign min_signal = (count <= MIN_C);
    assign empty      = (count == '0);

    // An ack with no outstanding request is not a delivery
    assign ack_valid = refill_ack && refill_req;
    // Decrement only on the completion that moves ACTUATE to RELEASE
    assign dec       = (state == ACTUATE) && enable && cork_done;

    assign timer_en    = (state == ACTUATE);
    assign timer_clear = (state != ACTUATE) || cork_done;

    modulo_timeout_rolhas #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cork_req && (count != '0)) begin
                    state_next = ACTUATE;
                end
            end
            ACTUATE: begin
                // A completion on the last allowed cycle still counts
                if (cork_done) begin
                    state_next = RELEASE;
                end else if (timer_expired) begin
                    state_next = FAULT;
                end
            end
            RELEASE: begin
                if (!cork_req) begin
                    state_next = IDLE;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!enable) begin
            state_next = IDLE;
        end
    end

    // Outputs are registered from the next state so they change with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cork_actuate <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_next;
            cork_actuate <= (state_next == ACTUATE);
            fault        <= (state_next == FAULT);
        end
    end

    always_comb begin
        count_sum = {1'b0, count};
        if (ack_valid) begin
            count_sum = count_sum + REFILL_S;
        end
        if (dec) begin
            count_sum = count_sum - SUM_W'(1);
        end
        if (count_sum > MAX_S) begin
            count_next = MAX_S[COUNT_W-1:0];
        end else begin
            count_next = count_sum[COUNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            refill_req <= 1'b0;
        end else begin
            count <= count_next;
            if (ack_valid) begin
                refill_req <= 1'b0;
            end else if (enable && min_signal && !refill_req) begin
                refill_req <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_modulo_controle_rolhas.sv
module tb_modulo_controle_rolhas;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       cork_req = 1'b0;
    logic       cork_done = 1'b0;
    logic       refill_ack = 1'b0;
    logic       cork_actuate;
    logic       refill_req;
    logic [4:0] count;
    logic       min_signal;
    logic       empty;
    logic       fault;

    // Second instance with a high threshold, used to reach the stock ceiling
    logic       enable2 = 1'b0;
    logic       refill_ack2 = 1'b0;
    logic       idle_in2 = 1'b0;
    logic       cork_actuate2;
    logic       refill_req2;
    logic [4:0] count2;
    logic       min_signal2;
    logic       empty2;
    logic       fault2;

    int total = 0;
    int passes = 0;
    int fails = 0;

    always #5 clk = ~clk;

    modulo_controle_rolhas dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .cork_req     (cork_req),
        .cork_done    (cork_done),
        .refill_ack   (refill_ack),
        .cork_actuate (cork_actuate),
        .refill_req   (refill_req),
        .count        (count),
        .min_signal   (min_signal),
        .empty        (empty),
        .fault        (fault)
    );

    modulo_controle_rolhas #(
        .MIN_THRESHOLD (30)
    ) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable2),
        .cork_req     (idle_in2),
        .cork_done    (idle_in2),
        .refill_ack   (refill_ack2),
        .cork_actuate (cork_actuate2),
        .refill_req   (refill_req2),
        .count        (count2),
        .min_signal   (min_signal2),
        .empty        (empty2),
        .fault        (fault2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // From IDLE with a pending bottle: ACTUATE, complete, bottle leaves
    task automatic dispense();
        cork_req = 1'b1;
        tick();
        cork_done = 1'b1;
        tick();
        cork_done = 1'b0;
        cork_req  = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_min", min_signal, 1);
        chk("rst_empty", empty, 1);
        chk("rst_refill_req", refill_req, 0);
        chk("rst_actuate", cork_actuate, 0);
        chk("rst_fault", fault, 0);
        #10 rst_n = 1'b1;
        tick();
        chk("disabled_no_req", refill_req, 0);

        // Empty stock: bottle waits, refill requested
        enable   = 1'b1;
        cork_req = 1'b1;
        tick();
        chk("empty_req_set", refill_req, 1);
        chk("empty_no_actuate", cork_actuate, 0);
        tick();
        chk("empty_still_idle", cork_actuate, 0);
        cork_req   = 1'b0;
        refill_ack = 1'b1;
        tick();
        refill_ack = 1'b0;
        chk("refill_count", count, 15);
        chk("refill_req_clr", refill_req, 0);
        chk("refill_min", min_signal, 0);
        chk("refill_empty", empty, 0);
        tick();
        chk("no_rerequest", refill_req, 0);
        refill_ack = 1'b1;
        tick();
        refill_ack = 1'b0;
        chk("stray_ack_ignored", count, 15);

        // One dispense with cork_req held: actuator high 3 cycles
        cork_req = 1'b1;
        tick();
        chk("act_cycle1", cork_actuate, 1);
        tick();
        chk("act_cycle2", cork_actuate, 1);
        chk("act_count_hold", count, 15);
        tick();
        chk("act_cycle3", cork_actuate, 1);
        cork_done = 1'b1;
        tick();
        cork_done = 1'b0;
        chk("dispense_count", count, 14);
        chk("release_actuate", cork_actuate, 0);
        tick(3);
        chk("held_req_no_redo", cork_actuate, 0);
        chk("held_req_count", count, 14);
        cork_req = 1'b0;
        tick();
        cork_req = 1'b1;
        tick();
        chk("second_bottle_act", cork_actuate, 1);
        cork_done = 1'b1;
        tick();
        cork_done = 1'b0;
        cork_req  = 1'b0;
        chk("second_dispense", count, 13);
        tick();

        repeat (7) dispense();
        chk("count_six", count, 6);
        chk("six_min", min_signal, 0);
        chk("six_no_req", refill_req, 0);

        // Crossing the threshold
        cork_req = 1'b1;
        tick();
        cork_done = 1'b1;
        tick();
        cork_done = 1'b0;
        cork_req  = 1'b0;
        chk("count_five", count, 5);
        chk("five_min", min_signal, 1);
        chk("five_req_not_yet", refill_req, 0);
        tick();
        chk("five_req_set", refill_req, 1);

        // Dispense and refill completing on the same edge
        cork_req = 1'b1;
        tick();
        chk("combo_act", cork_actuate, 1);
        cork_done  = 1'b1;
        refill_ack = 1'b1;
        tick();
        cork_done  = 1'b0;
        refill_ack = 1'b0;
        cork_req   = 1'b0;
        chk("combo_count", count, 19);
        chk("combo_req_clr", refill_req, 0);
        tick();
        chk("combo_no_req", refill_req, 0);

        // Saturation on the high-threshold instance
        enable2 = 1'b1;
        tick();
        chk("sat_req1", refill_req2, 1);
        refill_ack2 = 1'b1;
        tick();
        refill_ack2 = 1'b0;
        chk("sat_count15", count2, 15);
        tick();
        chk("sat_req2", refill_req2, 1);
        refill_ack2 = 1'b1;
        tick();
        refill_ack2 = 1'b0;
        chk("sat_count30", count2, 30);
        tick();
        refill_ack2 = 1'b1;
        tick();
        refill_ack2 = 1'b0;
        chk("sat_count31", count2, 31);
        chk("sat_req_clr", refill_req2, 0);
        tick();
        chk("sat_min_low", min_signal2, 0);
        chk("sat_no_req", refill_req2, 0);

        // Actuator timeout
        cork_req = 1'b1;
        tick();
        chk("to_act", cork_actuate, 1);
        tick(254);
        chk("to_edge_act", cork_actuate, 1);
        chk("to_edge_nofault", fault, 0);
        tick();
        chk("to_fault", fault, 1);
        chk("to_act_off", cork_actuate, 0);
        chk("to_count_kept", count, 19);
        cork_req = 1'b0;
        tick(2);
        chk("fault_latched", fault, 1);
        cork_req = 1'b1;
        tick();
        chk("fault_no_act", cork_actuate, 0);
        enable = 1'b0;
        tick();
        chk("fault_cleared", fault, 0);
        chk("disable_count_kept", count, 19);
        enable = 1'b1;
        tick();
        chk("restart_act", cork_actuate, 1);

        // Asynchronous reset in the middle of ACTUATE
        #2 rst_n = 1'b0;
        #1;
        chk("arst_actuate", cork_actuate, 0);
        chk("arst_count", count, 0);
        chk("arst_req", refill_req, 0);
        chk("arst_fault", fault, 0);
        chk("arst_empty", empty, 1);
        chk("arst_count2", count2, 0);
        cork_req = 1'b0;
        enable   = 1'b0;
        enable2  = 1'b0;
        #10 rst_n = 1'b1;
        tick(2);
        chk("post_rst_idle", cork_actuate, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
